remote_press_conditioner: RTL

Front-end stage between the eight raw active-low remote button lines and the answer/score checker. Synchronises and debounces every line, detects a single clean press, and presents it as a one-hot-low 8-bit code for a fixed number of cycles. Then locks out all further presses until the problem sequencer re-arms it and every button has been released. Its output drives the checker's 8-bit remote input directly. The checker's combinational "someone scored" result feeds back as `arm`.

---
 rtl/remote_press_conditioner.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/remote_press_conditioner.sv
// Remote button front end: sync, debounce, single-press capture, hold, lockout until re-armed.
// Define REMOTE_DEBOUNCE_EN to build the per-line debounce counters; otherwise stb follows the synchroniser.
//
// state    | meaning
// IDLE     | waiting for exactly one clean press
// CAPTURE  | presenting the captured code for HOLD_CYCLES cycles
// LOCKED   | presses ignored until arm (or a pending arm)
// WAIT_REL | re-armed, waiting for every button to be released
module remote_press_conditioner #(
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rm_raw,
  input  logic       arm,
  output logic [7:0] rm_bcd,
  output logic       rm_valid,
  output logic       locked,
  output logic       multi_err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, LOCKED, WAIT_REL} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] sync1, sync2;
  logic [7:0] stb, stb_prev;
  logic [7:0] press;
  logic       single, multi;
  logic [7:0] hold_cnt, hold_nxt;
  logic [7:0] code_nxt;
  logic       arm_pend, pend_nxt;
  logic       multi_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= rm_raw;
      sync2 <= sync1;
    end
  end

`ifdef REMOTE_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] deb_cnt [8];

  // A line's debounced value flips on the DEB_CYCLES-th consecutive disagreeing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb <= '1;
      for (int i = 0; i < 8; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] != stb[i]) begin
          if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            stb[i]     <= ~stb[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES > 0);
  assign stb = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) stb_prev <= '1;
    else     stb_prev <= stb;
  end

  assign press  = stb_prev & ~stb;
  assign single = (press != 8'h00) && ((press & (press - 8'd1)) == 8'h00);
  assign multi  = (press != 8'h00) && !single;

  always_comb begin
    state_nxt = state;
    code_nxt  = rm_bcd;
    hold_nxt  = hold_cnt;
    pend_nxt  = arm_pend;
    multi_nxt = 1'b0;
    case (state)
      IDLE: begin
        code_nxt = 8'hFF;
        if (single) begin
          state_nxt = CAPTURE;
          code_nxt  = ~press;
          hold_nxt  = HOLD_LOAD;
        end else if (multi) begin
          multi_nxt = 1'b1;
        end
      end
      CAPTURE: begin
        // The checker's score feedback arrives while we are still presenting.
        if (arm) pend_nxt = 1'b1;
        if (hold_cnt == 8'd0) begin
          state_nxt = LOCKED;
          code_nxt  = 8'hFF;
        end else begin
          hold_nxt = hold_cnt - 8'd1;
        end
      end
      LOCKED: begin
        code_nxt = 8'hFF;
        if (arm || arm_pend) state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        code_nxt = 8'hFF;
        if (stb == 8'hFF) begin
          state_nxt = IDLE;
          pend_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        code_nxt  = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      arm_pend  <= 1'b0;
      rm_bcd    <= 8'hFF;
      rm_valid  <= 1'b0;
      locked    <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      arm_pend  <= pend_nxt;
      rm_bcd    <= code_nxt;
      rm_valid  <= (state_nxt == CAPTURE);
      locked    <= (state_nxt == LOCKED) || (state_nxt == WAIT_REL);
      multi_err <= multi_nxt;
    end
  end

endmodule
